// File: rtl/i2s_dac_driver_sv.sv
// I2S DAC driver: stereo PCM in via valid/ready, MCLK/SCLK/LRCK/SDATA out.
// Optional `define I2S_MUTE_ON_UNDERRUN_EN silences frames that start with no sample pending.
module i2s_dac_driver_sv #(
   parameter int DATA_W      = 16,
   parameter int MCLK_DIV    = 4,
   parameter int SCLK_DIV    = 16,
   parameter int BITS_PER_CH = 32
) (
   input  logic              i_sysclk_40,
   input  logic              i_rst_n,
   input  logic [DATA_W-1:0] i_sample_l,
   input  logic [DATA_W-1:0] i_sample_r,
   input  logic              i_valid,
   output logic              o_ready,
   output logic              o_i2s_mclk,
   output logic              o_i2s_sclk,
   output logic              o_i2s_lrck,
   output logic              o_i2s_sdata,
   output logic              o_underrun
);

   localparam int FRAME = SCLK_DIV * 2 * BITS_PER_CH;
   localparam int CW    = $clog2(FRAME);
   localparam int MB    = $clog2(MCLK_DIV);
   localparam int SB    = $clog2(SCLK_DIV);
   localparam int SW    = CW - SB;

   localparam logic [CW-1:0] C_LAST  = CW'(FRAME - 1);
   localparam logic [SW-1:0] C_BPC   = SW'(BITS_PER_CH);
   localparam logic [SW-1:0] C_DW    = SW'(DATA_W);
   localparam logic [SW-1:0] C_R_END = SW'(BITS_PER_CH + DATA_W);

   logic [CW-1:0]     cnt;
   logic [SW-1:0]     slot;
   logic [SB-1:0]     phase;
   logic [DATA_W-1:0] hold_l, hold_r;
   logic [DATA_W-1:0] lat_l, lat_r;
   logic [DATA_W-1:0] shreg;
   logic              full, full_nxt;
   logic              accept, wrap_now;
   logic              in_l, in_r;
   logic              slot_start, slot_end;

   assign slot       = cnt[CW-1:SB];
   assign phase      = cnt[SB-1:0];
   assign wrap_now   = (cnt == '0);
   assign accept     = i_valid && o_ready;
   assign slot_start = (phase == '0);
   assign slot_end   = (phase == '1);
   // One-bit I2S delay: data starts one slot after each channel boundary
   assign in_l = (slot >= SW'(1)) && (slot <= C_DW);
   assign in_r = (slot > C_BPC) && (slot <= C_R_END);

   always_comb begin
      full_nxt = full;
      if (wrap_now && full)
         full_nxt = 1'b0;
      if (accept)
         full_nxt = 1'b1;
   end

   always_ff @(posedge i_sysclk_40 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt         <= '0;
         hold_l      <= '0;
         hold_r      <= '0;
         lat_l       <= '0;
         lat_r       <= '0;
         shreg       <= '0;
         full        <= 1'b0;
         o_ready     <= 1'b0;
         o_i2s_mclk  <= 1'b0;
         o_i2s_sclk  <= 1'b0;
         o_i2s_lrck  <= 1'b0;
         o_i2s_sdata <= 1'b0;
         o_underrun  <= 1'b0;
      end else begin
         cnt        <= (cnt == C_LAST) ? '0 : cnt + CW'(1);
         o_i2s_mclk <= cnt[MB-1];
         o_i2s_sclk <= cnt[SB-1];
         o_i2s_lrck <= (slot >= C_BPC);
         o_underrun <= wrap_now && !full;
         full       <= full_nxt;
         o_ready    <= !full_nxt;

         if (accept) begin
            hold_l <= i_sample_l;
            hold_r <= i_sample_r;
         end

         if (wrap_now) begin
            if (full) begin
               lat_l <= hold_l;
               lat_r <= hold_r;
            end else begin
`ifdef I2S_MUTE_ON_UNDERRUN_EN
               lat_l <= '0;
               lat_r <= '0;
`else
               lat_l <= lat_l;
               lat_r <= lat_r;
`endif
            end
         end

         // Shift reg reloads late in the boundary slot, after the latch settled
         if (slot_start) begin
            if (in_l || in_r) begin
               o_i2s_sdata <= shreg[DATA_W-1];
               shreg       <= shreg << 1;
            end else begin
               o_i2s_sdata <= 1'b0;
            end
         end else if (slot_end && slot == '0) begin
            shreg <= lat_l;
         end else if (slot_end && slot == C_BPC) begin
            shreg <= lat_r;
         end
      end
   end

endmodule
